// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Constants and types shared by the CPU memory port, the video frame-buffer
// fetch port, the SSRAM controller and the arbiter that sits between them.
//   - Bus widths: 30-bit word address, 32-bit data, 4 byte enables, 2-bit id.
//   - Transaction ids: ID_NONE (no return data), ID_DC / ID_IC (CPU caches),
//     ID_FB (frame-buffer fetch).
//   - grant_state_t: the arbiter's grant-lock state.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;
    localparam int ID_W   = 2;

    typedef logic [ID_W-1:0] id_t;

    localparam id_t ID_NONE = 2'd0;
    localparam id_t ID_DC   = 2'd1;
    localparam id_t ID_IC   = 2'd2;
    localparam id_t ID_FB   = 2'd3;

    // GRANT_FREE: arbitrate this cycle.
    // GRANT_CPU / GRANT_FB: the named master stalled last cycle and keeps the
    // slave until its transfer is accepted.
    typedef enum logic [1:0] {
        GRANT_FREE = 2'd0,
        GRANT_CPU  = 2'd1,
        GRANT_FB   = 2'd2
    } grant_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three memory ports around the arbiter:
//   cpu_*  : CPU (yari) request port, read return tagged by cpu_readdataid
//   fb_*   : video frame-buffer read-only fetch port
//   mem_*  : SSRAM controller port
// Modports:
//   slave  : the arbiter's view (takes CPU/FB requests, drives the SSRAM port)
//   master : the surrounding system's view (CPU, video and SSRAM together)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // CPU port
    logic              cpu_waitrequest;
    logic [ID_W-1:0]   cpu_id;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic [MASK_W-1:0] cpu_writedatamask;
    logic [DATA_W-1:0] cpu_readdata;
    logic [ID_W-1:0]   cpu_readdataid;

    // Frame-buffer port
    logic              fb_waitrequest;
    logic [ADDR_W-1:0] fb_address;
    logic              fb_read;
    logic [DATA_W-1:0] fb_readdata;
    logic              fb_readdatavalid;

    // SSRAM controller port
    logic              mem_waitrequest;
    logic [ID_W-1:0]   mem_id;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [MASK_W-1:0] mem_writedatamask;
    logic [DATA_W-1:0] mem_readdata;
    logic [ID_W-1:0]   mem_readdataid;

    modport slave (
        input  cpu_id, cpu_address, cpu_read, cpu_write,
               cpu_writedata, cpu_writedatamask,
        output cpu_waitrequest, cpu_readdata, cpu_readdataid,
        input  fb_address, fb_read,
        output fb_waitrequest, fb_readdata, fb_readdatavalid,
        input  mem_waitrequest, mem_readdata, mem_readdataid,
        output mem_id, mem_address, mem_read, mem_write,
               mem_writedata, mem_writedatamask
    );

    modport master (
        output cpu_id, cpu_address, cpu_read, cpu_write,
               cpu_writedata, cpu_writedatamask,
        input  cpu_waitrequest, cpu_readdata, cpu_readdataid,
        output fb_address, fb_read,
        input  fb_waitrequest, fb_readdata, fb_readdatavalid,
        output mem_waitrequest, mem_readdata, mem_readdataid,
        input  mem_id, mem_address, mem_read, mem_write,
               mem_writedata, mem_writedatamask
    );

endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-master / one-slave arbiter: CPU and video frame-buffer fetch share the
// SSRAM controller. Video has priority, but after FB_MAX_RUN consecutive
// accepted FB transfers with the CPU waiting, the CPU gets one slot. A master
// that is stalled by the slave keeps the grant until its transfer is accepted.
// Read data is returned combinationally and steered by mem_readdataid.
// Ports:
//   clock  : master clock
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave (cpu_*, fb_*, mem_* signal groups)
// Parameters:
//   FB_MAX_RUN : FB transfers allowed in a row while the CPU waits
//   ID_FB      : id stamped on FB requests and recognised on read returns
//   ID_NONE    : cpu_readdataid value meaning "no CPU data this cycle"
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int         FB_MAX_RUN = 8,
    parameter logic [1:0] ID_FB      = mem_arbiter_pkg::ID_FB,
    parameter logic [1:0] ID_NONE    = mem_arbiter_pkg::ID_NONE
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    import mem_arbiter_pkg::*;

    localparam int             RUN_W   = $clog2(FB_MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FB_MAX_RUN);

    grant_state_t     state;
    grant_state_t     state_next;
    logic [RUN_W-1:0] fb_run;

    logic cpu_req;
    logic fb_req;
    logic sel_fb;
    logic sel_req;
    logic accept_cpu;
    logic accept_fb;

    // Saturating increment of the FB run length.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
        if (run >= RUN_MAX) begin
            return RUN_MAX;
        end
        return run + 1'b1;
    endfunction

    assign cpu_req = bus.cpu_read | bus.cpu_write;
    assign fb_req  = bus.fb_read;

    // Grant selection. A locked grant ignores the other master entirely; only
    // a free arbiter with both masters requesting consults the run counter.
    always_comb begin
        sel_fb = fb_req;
        unique case (state)
            GRANT_CPU: sel_fb = 1'b0;
            GRANT_FB:  sel_fb = 1'b1;
            default: begin
                if (cpu_req && fb_req) begin
                    sel_fb = (fb_run < RUN_MAX);
                end else begin
                    sel_fb = fb_req;
                end
            end
        endcase
    end

    assign sel_req    = sel_fb ? fb_req : cpu_req;
    assign accept_fb  = sel_fb & fb_req & ~bus.mem_waitrequest;
    assign accept_cpu = ~sel_fb & cpu_req & ~bus.mem_waitrequest;

    // Grant-lock state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= GRANT_FREE;
        end else begin
            state <= state_next;
        end
    end

    // Next grant state. Lock only while the selected master is stalled. An
    // accepted transfer frees the arbiter, and so does a locked owner that
    // dropped its request (illegal under the Avalon hold rule, but recovering
    // is cheaper than wedging the bus).
    always_comb begin
        state_next = GRANT_FREE;
        if (sel_req && bus.mem_waitrequest) begin
            state_next = sel_fb ? GRANT_FB : GRANT_CPU;
        end
    end

    // FB run length: counts FB accepts that the CPU had to wait through.
    // Cleared as soon as the CPU is served or stops asking.
    always_ff @(posedge clock) begin
        if (reset) begin
            fb_run <= '0;
        end else if (!cpu_req || accept_cpu) begin
            fb_run <= '0;
        end else if (accept_fb) begin
            fb_run <= run_inc(fb_run);
        end
    end

    // Forwarding and wait outputs. Write data and mask always come from the
    // CPU; the slave ignores them on an FB read.
    always_comb begin
        bus.mem_id            = bus.cpu_id;
        bus.mem_address       = bus.cpu_address;
        bus.mem_read          = bus.cpu_read;
        bus.mem_write         = bus.cpu_write;
        bus.mem_writedata     = bus.cpu_writedata;
        bus.mem_writedatamask = bus.cpu_writedatamask;
        if (sel_fb) begin
            bus.mem_id      = ID_FB;
            bus.mem_address = bus.fb_address;
            bus.mem_read    = bus.fb_read;
            bus.mem_write   = 1'b0;
        end
        // The unselected master is held off even when it is not requesting.
        bus.cpu_waitrequest = bus.mem_waitrequest | sel_fb;
        bus.fb_waitrequest  = bus.mem_waitrequest | ~sel_fb;
    end

    // Read return: no storage, the tag alone decides the recipient, so
    // out-of-order returns from the slave need no tracking here.
    always_comb begin
        bus.cpu_readdata     = bus.mem_readdata;
        bus.fb_readdata      = bus.mem_readdata;
        bus.fb_readdatavalid = (bus.mem_readdataid == ID_FB);
        bus.cpu_readdataid   = (bus.mem_readdataid == ID_FB) ? ID_NONE
                                                              : bus.mem_readdataid;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int RUN_MAX = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if bus();

    mem_arbiter #(
        .FB_MAX_RUN (RUN_MAX),
        .ID_FB      (2'd3),
        .ID_NONE    (2'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // The CPU must never use the FB tag.
    always @(posedge clock) begin
        if (!reset && (bus.cpu_read || bus.cpu_write)) begin
            assert (bus.cpu_id != 2'd3) else $error("cpu_id carries the FB tag");
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic settle();
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.cpu_id            = 2'd1;
        bus.cpu_address       = '0;
        bus.cpu_read          = 1'b0;
        bus.cpu_write         = 1'b0;
        bus.cpu_writedata     = '0;
        bus.cpu_writedatamask = '0;
        bus.fb_address        = '0;
        bus.fb_read           = 1'b0;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdata      = '0;
        bus.mem_readdataid    = 2'd0;
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: -1 nobody holds the slave, 0 CPU holds it, 1 FB holds it.
    // streak: FB transfers served in a row while the CPU kept asking.
    int owner  = -1;
    int streak = 0;

    function automatic bit model_fb_wins();
        bit c = bus.cpu_read || bus.cpu_write;
        bit f = bus.fb_read;
        if (owner == 1) return 1'b1;
        if (owner == 0) return 1'b0;
        if (c && f) return (streak < RUN_MAX);
        return f;
    endfunction

    function automatic logic [127:0] model_expect();
        bit fbw = model_fb_wins();
        logic [1:0]  id   = fbw ? 2'd3 : bus.cpu_id;
        logic [29:0] addr = fbw ? bus.fb_address : bus.cpu_address;
        logic        rd   = fbw ? bus.fb_read : bus.cpu_read;
        logic        wr   = fbw ? 1'b0 : bus.cpu_write;
        logic        cw   = bus.mem_waitrequest || fbw;
        logic        fw   = bus.mem_waitrequest || !fbw;
        logic        fv   = (bus.mem_readdataid == 2'd3);
        logic [1:0]  crid = fv ? 2'd0 : bus.mem_readdataid;
        return {id, addr, rd, wr, bus.cpu_writedata, bus.cpu_writedatamask,
                cw, fw, bus.mem_readdata, crid, fv};
    endfunction

    function automatic logic [127:0] dut_outputs();
        return {bus.mem_id, bus.mem_address, bus.mem_read, bus.mem_write,
                bus.mem_writedata, bus.mem_writedatamask,
                bus.cpu_waitrequest, bus.fb_waitrequest,
                bus.cpu_readdata, bus.cpu_readdataid, bus.fb_readdatavalid};
    endfunction

    task automatic model_step();
        bit c    = bus.cpu_read || bus.cpu_write;
        bit fbw  = model_fb_wins();
        bit mine = fbw ? bus.fb_read : c;
        bit done = mine && !bus.mem_waitrequest;
        if (reset) begin
            owner  = -1;
            streak = 0;
        end else begin
            owner = (mine && bus.mem_waitrequest) ? int'(fbw) : -1;
            if (!c || (!fbw && done)) streak = 0;
            else if (fbw && done && streak < RUN_MAX) streak = streak + 1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        cpu_rd;
        logic        fb_rd;
        logic        mwait;
        logic [1:0]  rdid;
        logic [31:0] rdata;
        logic        exp_fv;
        logic [1:0]  exp_crid;
        logic        exp_cw;
        logic        exp_fw;
        logic        exp_mrd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int accepts;
        bit exp_fb;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h12345678, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'hA5A5_0001, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd2, 32'h0BAD_F00D, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0042, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd3, 32'hCAFE_0003, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h7777_8888, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'hFFFF_0000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};

        clear_in();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset / idle state.
        bus.mem_waitrequest = 1'b1;
        settle();
        chk("idle rd/wr", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("idle waits mw1", {bus.cpu_waitrequest, bus.fb_waitrequest}, 2'b11);
        next_cycle();
        bus.mem_waitrequest = 1'b0;
        settle();
        chk("idle waits mw0", {bus.cpu_waitrequest, bus.fb_waitrequest}, 2'b01);
        next_cycle();

        // Table vectors: return steering and single-cycle waits.
        for (int i = 0; i < 7; i++) begin
            bus.cpu_read        = vecs[i].cpu_rd;
            bus.cpu_id          = 2'd1;
            bus.fb_read         = vecs[i].fb_rd;
            bus.mem_waitrequest = vecs[i].mwait;
            bus.mem_readdataid  = vecs[i].rdid;
            bus.mem_readdata    = vecs[i].rdata;
            settle();
            chk($sformatf("vec%0d", i),
                {bus.fb_readdatavalid, bus.cpu_readdataid, bus.cpu_waitrequest,
                 bus.fb_waitrequest, bus.mem_read, bus.mem_write,
                 bus.cpu_readdata, bus.fb_readdata},
                {vecs[i].exp_fv, vecs[i].exp_crid, vecs[i].exp_cw,
                 vecs[i].exp_fw, vecs[i].exp_mrd, 1'b0,
                 vecs[i].rdata, vecs[i].rdata});
            next_cycle();
        end
        clear_in();
        next_cycle();

        // FB only, four cycles, no stall.
        accepts = 0;
        for (int k = 0; k < 4; k++) begin
            bus.fb_read    = 1'b1;
            bus.fb_address = 30'h200 + 30'(k);
            settle();
            chk($sformatf("fb only c%0d", k),
                {bus.mem_id, bus.mem_address, bus.mem_read, bus.mem_write, bus.cpu_waitrequest},
                {2'd3, 30'h200 + 30'(k), 1'b1, 1'b0, 1'b1});
            if (!bus.fb_waitrequest) accepts++;
            next_cycle();
        end
        chk("fb only accepts", 32'(accepts), 32'd4);
        clear_in();
        next_cycle();

        // CPU write stalled three cycles; FB arrives mid-stall.
        bus.cpu_write = 1'b1; bus.cpu_id = 2'd1; bus.cpu_address = 30'h100;
        bus.cpu_writedata = 32'hDEADBEEF; bus.cpu_writedatamask = 4'b0011;
        bus.fb_address = 30'h2AA;
        for (int k = 1; k <= 5; k++) begin
            bus.fb_read         = (k >= 2);
            bus.mem_waitrequest = (k <= 3);
            if (k == 5) bus.cpu_write = 1'b0;
            settle();
            if (k <= 4) begin
                chk($sformatf("cpu lock c%0d", k),
                    {bus.mem_id, bus.mem_address, bus.mem_write, bus.mem_read,
                     bus.mem_writedata, bus.mem_writedatamask,
                     bus.cpu_waitrequest, bus.fb_waitrequest},
                    {2'd1, 30'h100, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0011,
                     (k <= 3), 1'b1});
            end else begin
                chk("fb after cpu",
                    {bus.mem_id, bus.mem_address, bus.mem_read, bus.mem_write,
                     bus.cpu_waitrequest, bus.fb_waitrequest},
                    {2'd3, 30'h2AA, 1'b1, 1'b0, 1'b1, 1'b0});
            end
            next_cycle();
        end
        clear_in();
        next_cycle();

        // Both requesting continuously: 8 FB then 1 CPU, three rounds.
        bus.cpu_read = 1'b1; bus.cpu_id = 2'd2; bus.fb_read = 1'b1;
        for (int k = 0; k < 27; k++) begin
            exp_fb = ((k % 9) != 8);
            settle();
            chk($sformatf("starve c%0d", k),
                {bus.mem_id, bus.fb_waitrequest, bus.cpu_waitrequest},
                {exp_fb ? 2'd3 : 2'd2, !exp_fb, exp_fb});
            next_cycle();
        end
        clear_in();
        next_cycle();

        // Reset during a locked FB stall drops the lock.
        bus.fb_read = 1'b1; bus.mem_waitrequest = 1'b1;
        settle();
        chk("fb stall", {bus.mem_id, bus.mem_read}, {2'd3, 1'b1});
        next_cycle();
        reset = 1'b1;
        bus.cpu_write = 1'b1; bus.cpu_id = 2'd2; bus.cpu_address = 30'h55;
        settle();
        chk("fb still locked", {bus.mem_id, bus.mem_write}, {2'd3, 1'b0});
        next_cycle();
        reset = 1'b0;
        bus.fb_read = 1'b0;
        settle();
        chk("cpu after reset",
            {bus.mem_id, bus.mem_address, bus.mem_write, bus.fb_waitrequest},
            {2'd2, 30'h55, 1'b1, 1'b1});
        next_cycle();
        clear_in();
        next_cycle();

        // Reset clears a partial FB run: 5 FB accepts, reset, then a full 8.
        bus.cpu_read = 1'b1; bus.cpu_id = 2'd1; bus.fb_read = 1'b1;
        for (int k = 0; k < 5; k++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_fb = (k < 8);
            settle();
            chk($sformatf("run reset c%0d", k), {bus.fb_waitrequest}, {!exp_fb});
            next_cycle();
        end
        clear_in();

        // Randomised traffic against the reference model.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        owner = -1;
        streak = 0;
        for (int n = 0; n < 3000; n++) begin
            int op = $urandom_range(0, 9);
            bus.cpu_read          = (op < 3);
            bus.cpu_write         = (op >= 3 && op < 6) || (op == 9);
            bus.cpu_id            = 2'($urandom_range(0, 2));
            bus.cpu_address       = 30'($urandom);
            bus.cpu_writedata     = $urandom;
            bus.cpu_writedatamask = 4'($urandom);
            bus.fb_read           = ($urandom_range(0, 9) < 7);
            bus.fb_address        = 30'($urandom);
            bus.mem_waitrequest   = ($urandom_range(0, 9) < 3);
            bus.mem_readdataid    = 2'($urandom);
            bus.mem_readdata      = $urandom;
            reset                 = ($urandom_range(0, 199) == 0);
            settle();
            chk($sformatf("rand c%0d", n), dut_outputs(), model_expect());
            model_step();
            next_cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter between the CPU memory port (yari) and the video frame-buffer fetch port on one side, and the SSRAM controller on the other.
- It replaces the plain priority mux in the board top level.
- Video has priority, bounded by a starvation limit. Grant is locked while a granted request stalls. Read data is steered by readdataid.

Parameters:
- FB_MAX_RUN, 8: max consecutive accepted FB transfers while the CPU is waiting; then the CPU gets one slot.
- ID_FB, 2'd3: transaction id stamped on FB requests; the FB read-return tag.
- ID_NONE, 2'd0: readdataid value meaning "no data this cycle".

Ports:
- clock  in  1  master clock
- reset  in  1  synchronous, active-high
- cpu_waitrequest  out  1  CPU stall
- cpu_id  in  2  CPU transaction id (never ID_FB)
- cpu_address  in  30  word address
- cpu_read  in  1  read strobe
- cpu_write  in  1  write strobe
- cpu_writedata  in  32  write data
- cpu_writedatamask  in  4  byte enables
- cpu_readdata  out  32  return data
- cpu_readdataid  out  2  return tag; ID_NONE when the data belongs to FB
- fb_waitrequest  out  1  FB stall
- fb_address  in  30  word address
- fb_read  in  1  read strobe
- fb_readdata  out  32  return data
- fb_readdatavalid  out  1  FB data valid
- mem_waitrequest  in  1  slave stall
- mem_id  out  2  forwarded id
- mem_address  out  30  forwarded address
- mem_read  out  1  forwarded read strobe
- mem_write  out  1  forwarded write strobe
- mem_writedata  out  32  forwarded write data
- mem_writedatamask  out  4  forwarded byte enables
- mem_readdata  in  32  slave return data
- mem_readdataid  in  2  slave return tag

Behaviour:
- Signal definitions:
  - cpu_req = cpu_read | cpu_write
  - fb_req = fb_read
  - A transfer is accepted in a cycle where the selected master requests and mem_waitrequest = 0.
- State registers:
  - lock (1 bit), lock_fb (1 bit), fb_run (counter, width clog2(FB_MAX_RUN+1)).
  - Reset values: all 0. Reset mid-stall drops the lock; the next cycle arbitrates fresh.
- Selection (combinational, zero added latency):
  - lock = 1: sel_fb = lock_fb.
  - Otherwise, when both request: sel_fb = (fb_run < FB_MAX_RUN).
  - Otherwise: sel_fb = fb_req. With neither requesting, the CPU is selected.
- Lock update each cycle:
  - Selected master requests and mem_waitrequest = 1: lock <= 1, lock_fb <= sel_fb.
  - Transfer accepted: lock <= 0.
  - Otherwise: hold. A locked grant never switches before acceptance.
  - A master that deasserts its request while locked is illegal (the Avalon hold rule). The arbiter then clears lock when the locked owner has no request.
- fb_run update:
  - Accepted FB transfer with cpu_req = 1: increment, saturating at FB_MAX_RUN.
  - Accepted CPU transfer, or cpu_req = 0: cleared to 0.
  - Otherwise: hold.
- Forwarding when sel_fb = 1:
  - mem_id = ID_FB, mem_address = fb_address, mem_read = fb_read, mem_write = 0.
  - writedata and writedatamask still come from cpu_* (don't-care on a read).
- Forwarding when sel_fb = 0: all mem_* = cpu_*.
- Wait signals:
  - cpu_waitrequest = mem_waitrequest | sel_fb
  - fb_waitrequest = mem_waitrequest | !sel_fb
  - A non-selected master sees waitrequest = 1 even with no request pending.
- Return path (combinational, no storage; out-of-order returns are handled by the tags):
  - cpu_readdata = fb_readdata = mem_readdata.
  - fb_readdatavalid = (mem_readdataid == ID_FB).
  - cpu_readdataid = ID_NONE when mem_readdataid == ID_FB, else mem_readdataid.
- Illegal cpu_id == ID_FB: forwarded unchanged, flagged by a bench assertion only.
- cpu_read and cpu_write both high: forwarded unchanged; slave-defined behaviour.

Decomposition:
- Shared package (or the existing pipeconnect header): ID_NONE/ID_DC/ID_IC/ID_FB constants, the 30-bit address width and the 32-bit data width, shared with the CPU, video and SSRAM controller.
- No sub-module needed.
- The saturating run counter is kept inline: a separate module would add ports without reuse.

Test Plan:
- FB only, fb_read held 4 cycles, mem_waitrequest = 0 -> 4 accepts; mem_id = 3, mem_write = 0, cpu_waitrequest = 1 throughout.
- CPU write, address 30'h100, data 32'hDEADBEEF, mask 4'b0011, mem_waitrequest high for 3 cycles; fb_read asserted in stall cycle 2 -> mem_* stays on the CPU until the accept in cycle 4; the FB is granted in cycle 5.
- Both requesting continuously, no slave stall, FB_MAX_RUN = 8 -> exactly 8 FB accepts, then 1 CPU accept, repeating (pattern 8:1); fb_run returns to 0 after each CPU accept.
- Return steering:
  - mem_readdataid = 3, readdata 32'h12345678 -> fb_readdatavalid = 1, cpu_readdataid = 0.
  - mem_readdataid = 1 -> fb_readdatavalid = 0, cpu_readdataid = 1.
- Reset asserted during a locked FB stall -> next cycle lock = 0, fb_run = 0; a pending CPU request with fb_req = 0 is selected immediately.
- Idle (no requests) -> mem_read = mem_write = 0, cpu_waitrequest = mem_waitrequest, fb_waitrequest = 1.
